// File: rtl/n64adv_joybus_pkg.sv
// Shared Joybus transmit definitions: FSM states, quarter counts per symbol and
// how many leading quarters of each symbol hold the line low.
package n64adv_joybus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_BIT       = 2'd2,
    ST_STOP      = 2'd3
  } tx_state_e;

  localparam int unsigned BIT_QUARTERS  = 4;
  localparam int unsigned STOP_QUARTERS = 3;

  localparam int unsigned BIT0_LOW = 3;
  localparam int unsigned BIT1_LOW = 1;
  localparam int unsigned STOP_LOW = 1;

  // A symbol drives low for its first low_cnt quarters, then releases.
  function automatic logic quarter_low(input logic [1:0] quarter, input int unsigned low_cnt);
    return (32'(quarter) < low_cnt);
  endfunction

endpackage

// File: rtl/joybus_quarter_tick.sv
// Quarter-time prescaler: one-cycle tick every CLK_PER_US cycles; held at zero
// while clr_i is high, so the first tick lands CLK_PER_US cycles after release.
module joybus_quarter_tick #(
  parameter int CLK_PER_US = 49
) (
  input  logic VCLK,
  input  logic nVRST,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          at_end;

  assign at_end = (cnt_q == PW'(CLK_PER_US - 1));
  assign tick_o = at_end & ~clr_i;

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clr_i || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/n64_joybus_tx.sv
// Joybus serializer: line low one cycle after accept, (32*len+3) quarters to tx_done; no queueing.
// Optional JOYBUS_TX_IDLECHK_EN waits for IDLE_US of continuous high line before the first bit.
module n64_joybus_tx
  import n64adv_joybus_pkg::*;
#(
  parameter int CLK_PER_US = 49,
  parameter int MAX_BYTES  = 4,
  parameter int IDLE_US    = 8
) (
  input  logic                   VCLK,
  input  logic                   nVRST,
  input  logic                   tx_start,
  input  logic [2:0]             tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic                   ctrl_in,
  output logic                   ctrl_oe,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int SW = 8 * MAX_BYTES;
  localparam int BW = (SW > 1) ? $clog2(SW) : 1;
  localparam int LW = $clog2(MAX_BYTES + 1);

  tx_state_e     state_q;
  logic [1:0]    quarter_q;
  logic [BW-1:0] bit_cnt_q;
  logic [LW-1:0] len_q;
  logic [SW-1:0] sr_q;
  logic          oe_q;
  logic          busy_q;
  logic          done_q;

  logic          accept;
  logic          tick;
  logic          tick_clr;
  logic [LW-1:0] len_clamped;
  logic [SW-1:0] sr_load;
  logic [BW-1:0] last_bit;
  logic          cur_bit;

`ifdef JOYBUS_TX_IDLECHK_EN
  localparam int IDLE_CYC = IDLE_US * CLK_PER_US;
  localparam int IW       = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  logic [IW-1:0] idle_cnt_q;
`else
  logic unused_ctrl_in;
  assign unused_ctrl_in = ctrl_in;
`endif

  assign accept      = tx_start && !busy_q && (tx_len != 3'd0);
  assign len_clamped = (int'(tx_len) > MAX_BYTES) ? LW'(MAX_BYTES) : LW'(tx_len);
  assign last_bit    = BW'(int'(len_q) * 8 - 1);
  assign cur_bit     = sr_q[SW-1];
  assign tick_clr    = (state_q != ST_BIT) && (state_q != ST_STOP);

  // Byte 0 lands in the top of the shift register so a plain left shift sends it first, MSB first.
  always_comb begin
    sr_load = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      sr_load[8*(MAX_BYTES-1-k) +: 8] = tx_data[8*k +: 8];
    end
  end

  joybus_quarter_tick #(
    .CLK_PER_US(CLK_PER_US)
  ) u_quarter_tick (
    .VCLK  (VCLK),
    .nVRST (nVRST),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      state_q    <= ST_IDLE;
      quarter_q  <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      sr_q       <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef JOYBUS_TX_IDLECHK_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            len_q     <= len_clamped;
            sr_q      <= sr_load;
            bit_cnt_q <= '0;
            quarter_q <= '0;
            busy_q    <= 1'b1;
`ifdef JOYBUS_TX_IDLECHK_EN
            state_q    <= ST_WAIT_LINE;
            oe_q       <= 1'b0;
            idle_cnt_q <= '0;
`else
            state_q   <= ST_BIT;
            oe_q      <= 1'b1;
`endif
          end
        end

`ifdef JOYBUS_TX_IDLECHK_EN
        // Any low sample restarts the quiet-line count; no timeout.
        ST_WAIT_LINE: begin
          if (!ctrl_in) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == IW'(IDLE_CYC - 1)) begin
            state_q <= ST_BIT;
            oe_q    <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + IW'(1);
          end
        end
`endif

        ST_BIT: begin
          if (tick) begin
            if (quarter_q == 2'(BIT_QUARTERS - 1)) begin
              quarter_q <= '0;
              oe_q      <= 1'b1;
              if (bit_cnt_q == last_bit) begin
                state_q <= ST_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
                sr_q      <= sr_q << 1;
              end
            end else begin
              quarter_q <= quarter_q + 2'd1;
              oe_q      <= quarter_low(quarter_q + 2'd1, cur_bit ? BIT1_LOW : BIT0_LOW);
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (quarter_q == 2'(STOP_QUARTERS - 1)) begin
              state_q   <= ST_IDLE;
              quarter_q <= '0;
              oe_q      <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              quarter_q <= quarter_q + 2'd1;
              oe_q      <= quarter_low(quarter_q + 2'd1, STOP_LOW);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_oe = oe_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
